// File: rtl/seg7_scan_driver.sv
// Multiplexed DIGITS-digit 7-segment driver with per-frame snapshot and a blanking guard per slot.
// Optional leading-zero suppression is enabled by defining SEG7_LZ_BLANK_EN.

module decode_7seg_hex (
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);
    // Segment order is {g,f,e,d,c,b,a}; a 1 lights the segment.
    always_comb begin
        o_seg = 7'h00;
        case (i_nibble)
            4'h0: o_seg = 7'h3F;
            4'h1: o_seg = 7'h06;
            4'h2: o_seg = 7'h5B;
            4'h3: o_seg = 7'h4F;
            4'h4: o_seg = 7'h66;
            4'h5: o_seg = 7'h6D;
            4'h6: o_seg = 7'h7D;
            4'h7: o_seg = 7'h07;
            4'h8: o_seg = 7'h7F;
            4'h9: o_seg = 7'h6F;
            4'hA: o_seg = 7'h77;
            4'hB: o_seg = 7'h7C;
            4'hC: o_seg = 7'h39;
            4'hD: o_seg = 7'h5E;
            4'hE: o_seg = 7'h79;
            4'hF: o_seg = 7'h71;
            default: o_seg = 7'h00;
        endcase
    end
endmodule

module seg7_scan_driver #(
    parameter int DIGITS          = 4,
    parameter int DIV             = 256,
    parameter int BLANK           = 16,
    parameter int DIG_ACTIVE_HIGH = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  seg_pol,
    output logic [6:0]            seg_out,
    output logic [DIGITS-1:0]     dig_out,
    output logic                  frame_tick
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] DIG_OFF  = (DIG_ACTIVE_HIGH != 0) ? {DIGITS{1'b0}} : {DIGITS{1'b1}};

    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic [4*DIGITS-1:0] r_snap;
    logic [6:0]          r_seg;
    logic [DIGITS-1:0]   r_dig;
    logic                r_tick;

    logic [3:0]          w_nibble;
    logic [6:0]          w_dec;
    logic [DIGITS-1:0]   w_onehot;
    logic [DIGITS-1:0]   w_lz_off;
    logic                w_frame_start;
    logic                w_show;

    assign w_nibble      = r_snap[4*int'(r_idx) +: 4];
    assign w_onehot      = DIGITS'(1) << r_idx;
    assign w_frame_start = enable && (r_cnt == '0) && (r_idx == '0);

    decode_7seg_hex u_dec (
        .i_nibble (w_nibble),
        .o_seg    (w_dec)
    );

`ifdef SEG7_LZ_BLANK_EN
    // Digit k is suppressed when it and every higher nibble of the snapshot are zero.
    always_comb begin
        logic lz_acc;
        lz_acc   = 1'b1;
        w_lz_off = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            lz_acc      = lz_acc && (r_snap[4*k +: 4] == 4'h0);
            w_lz_off[k] = lz_acc && (k != 0);
        end
    end
`else
    assign w_lz_off = '0;
`endif

    assign w_show = enable && (r_cnt >= CNT_W'(BLANK)) && !w_lz_off[r_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_idx  <= '0;
            r_snap <= '0;
            r_tick <= 1'b0;
            r_seg  <= {7{~seg_pol}};
            r_dig  <= DIG_OFF;
        end else begin
            r_tick <= w_frame_start;
            if (w_frame_start)
                r_snap <= value;

            if (!enable) begin
                r_cnt <= '0;
                r_idx <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_cnt <= '0;
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            // Snapshot edge has cnt == 0 < BLANK, so a lit slot never sees a half-loaded snap.
            if (w_show) begin
                r_dig <= w_onehot ^ DIG_OFF;
                r_seg <= seg_pol ? w_dec : ~w_dec;
            end else begin
                r_dig <= DIG_OFF;
                r_seg <= {7{~seg_pol}};
            end
        end
    end

    assign seg_out    = r_seg;
    assign dig_out    = r_dig;
    assign frame_tick = r_tick;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (DIGITS=4, DIV=8, BLANK=2): directed scenarios push
// expected {frame_tick, dig_out, seg_out} per cycle; a negedge monitor pops and compares.

module tb_seg7_scan_driver;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic [15:0] value = 16'h1234;
    logic        seg_pol = 1'b1;
    logic [6:0]  seg_out;
    logic [3:0]  dig_out;
    logic        frame_tick;

`ifdef SEG7_LZ_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    seg7_scan_driver #(
        .DIGITS          (4),
        .DIV             (8),
        .BLANK           (2),
        .DIG_ACTIVE_HIGH (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .value      (value),
        .seg_pol    (seg_pol),
        .seg_out    (seg_out),
        .dig_out    (dig_out),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // Hand-coded hex glyphs, {g,f,e,d,c,b,a}.
    logic [6:0] seg_tab [16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                 7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                 7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                                 7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

    logic [11:0] exp_q[$];
    string       name_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    localparam logic [11:0] OFF_HI = {1'b0, 4'b0000, 7'b0000000};

    // Cycle n counts from the first enabled edge (cycle 0); a frame is 32 cycles, cycle 1 carries the tick.
    function automatic logic [11:0] exp_scan(int n, logic [15:0] v, logic pol, logic lz);
        int         phase, d, p;
        logic [3:0] nib, dig;
        logic [6:0] seg;
        logic       tick;
        logic [15:0] hi;
        phase = (n - 1) % 32;
        d     = phase / 8;
        p     = phase % 8;
        tick  = (phase == 0);
        nib   = v[4*d +: 4];
        hi    = v >> (4 * d);
        if (p >= 2 && !(lz && d >= 1 && hi == 16'h0)) begin
            dig = 4'b0001 << d;
            seg = pol ? seg_tab[nib] : ~seg_tab[nib];
        end else begin
            dig = 4'b0000;
            seg = pol ? 7'b0000000 : 7'b1111111;
        end
        return {tick, dig, seg};
    endfunction

    task automatic cyc(input logic [11:0] e, input string nm);
        @(posedge clk);
        exp_q.push_back(e);
        name_q.push_back(nm);
        #1;
    endtask

    task automatic do_reset(input logic pol);
        reset   = 1'b1;
        enable  = 1'b1;
        seg_pol = pol;
        cyc({1'b0, 4'b0000, pol ? 7'b0000000 : 7'b1111111}, "reset");
        cyc({1'b0, 4'b0000, pol ? 7'b0000000 : 7'b1111111}, "reset");
        reset   = 1'b0;
        seg_pol = 1'b1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [11:0] e, a;
            string       nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {frame_tick, dig_out, seg_out};
            n_checks++;
            if (a === e) n_pass++;
            else $display("FAIL %s: got tick=%b dig=%b seg=%b, want tick=%b dig=%b seg=%b",
                          nm, a[11], a[10:7], a[6:0], e[11], e[10:7], e[6:0]);
        end
    end

    initial begin
        // Normal scan, then a mid-frame reset at cycle 40.
        value = 16'h1234;
        do_reset(1'b1);
        for (int n = 1; n <= 40; n++)
            cyc(exp_scan(n, 16'h1234, 1'b1, LZ), $sformatf("scan c%0d", n));

        // Reset with active-low polarity shows all-ones off level.
        do_reset(1'b0);

        // Tearing: value changes at cycle 10, visible only from the next frame.
        value = 16'h1234;
        for (int n = 1; n <= 64; n++) begin
            cyc(exp_scan(n, (n <= 32) ? 16'h1234 : 16'hFFFF, 1'b1, LZ), $sformatf("tear c%0d", n));
            if (n == 10) value = 16'hFFFF;
        end

        // Enable drop at cycle 5, reassert at cycle 20 with a new value.
        do_reset(1'b1);
        value = 16'h1234;
        for (int n = 1; n <= 36; n++) begin
            if (n <= 5)       cyc(exp_scan(n, 16'h1234, 1'b1, LZ), $sformatf("en c%0d", n));
            else if (n <= 20) cyc(OFF_HI, $sformatf("en off c%0d", n));
            else              cyc(exp_scan(n - 20, 16'hABCD, 1'b1, LZ), $sformatf("en re c%0d", n));
            if (n == 5)  begin enable = 1'b0; value = 16'hABCD; end
            if (n == 20) enable = 1'b1;
        end

        // Polarity flips to active-low inside the digit-0 lit window.
        do_reset(1'b1);
        value = 16'h1234;
        for (int n = 1; n <= 12; n++) begin
            cyc(exp_scan(n, 16'h1234, (n >= 5) ? 1'b0 : 1'b1, LZ), $sformatf("pol c%0d", n));
            if (n == 4) seg_pol = 1'b0;
        end
        seg_pol = 1'b1;

        // Leading zeros: 0x0070 then 0x0000 (suppressed only when the feature is built in).
        do_reset(1'b1);
        value = 16'h0070;
        for (int n = 1; n <= 64; n++) begin
            cyc(exp_scan(n, (n <= 32) ? 16'h0070 : 16'h0000, 1'b1, LZ), $sformatf("lz c%0d", n));
            if (n == 10) value = 16'h0000;
        end

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
